// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: valid/ready push side, one-at-a-time drain sequencer
// that issues a write strobe only while uart_tx is idle.
module uart_tx_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_char,
    output logic                  o_write,
    input  logic                  i_busy,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [TW-1:0]         timer;
    logic                  push;
    logic                  pop;
    logic                  ack_expired;

    // Full/ready come from the registered level, so a pop on the same edge
    // never frees room for a push that arrives while full.
    assign o_full      = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty     = (level == '0);
    assign o_ready     = !o_full;
    assign o_level     = level;
    assign push        = i_valid && !o_full;
    assign pop         = (state == IDLE) && !o_empty && !i_busy;
    assign ack_expired = (timer == TW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop) state_nxt = SEND;
            SEND:      state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (i_busy)           state_nxt = WAIT_DONE;
                else if (ack_expired) state_nxt = IDLE;
            end
            WAIT_DONE: if (!i_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            timer      <= '0;
            o_write    <= 1'b0;
            o_char     <= '0;
            o_overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_write <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                o_char <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
            if (i_valid && o_full) o_overflow <= 1'b1;
            // Timer counts idle cycles after the strobe; a uart_tx that never
            // raises busy still lets the sequencer move on.
            if (state == SEND)
                timer <= '0;
            else if (state == WAIT_ACK && !i_busy && !ack_expired)
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart_tx busy model and a
// data/level scoreboard updated every clock.
module tb_uart_tx_fifo;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_char;
    logic       o_write;
    logic       i_busy;
    logic [4:0] o_level;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;

    always #5 i_clk = ~i_clk;

    uart_tx_fifo #(.WIDTH(8), .DEPTH_LOG2(4), .ACK_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_char(o_char), .o_write(o_write), .i_busy(i_busy),
        .o_level(o_level), .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow)
    );

    int errs   = 0;
    int checks = 0;

    int   exp_level = 0;
    logic [7:0] exp_q[$];
    int   strobes   = 0;
    int   busy_viol = 0;
    int   dbl_viol  = 0;
    int   cyc       = 0;
    int   last_t    = 0;
    int   prev_t    = 0;
    logic prev_wr   = 1'b0;
    bit   lvl_chk   = 0;
    bit   model_en  = 0;
    int   busy_len  = 10;
    int   busy_cnt  = 0;
    logic wr_seen   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: update the scoreboard, then advance the uart_tx busy model.
    task automatic tick();
        bit   acc;
        logic busy_at_edge;
        acc = i_valid && (exp_level < 16) && !i_reset;
        if (acc) exp_q.push_back(i_data);
        busy_at_edge = i_busy;
        @(posedge i_clk);
        #1;
        cyc++;
        if (i_reset) begin
            exp_level = 0;
            exp_q.delete();
        end else begin
            if (acc) exp_level++;
            if (o_write === 1'b1) begin
                strobes++;
                prev_t = last_t;
                last_t = cyc;
                if (busy_at_edge) busy_viol++;
                if (prev_wr === 1'b1) dbl_viol++;
                exp_level--;
                if (exp_q.size() > 0) check("char_order", o_char, exp_q.pop_front());
                else check("spurious_strobe", 1, 0);
            end
        end
        if (lvl_chk) check("level_sb", o_level, exp_level);
        prev_wr = o_write;
        if (model_en) begin
            if (wr_seen === 1'b1) begin
                i_busy   = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) i_busy = 1'b0;
            end
        end
        wr_seen = o_write;
    endtask

    task automatic push_byte(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (!(o_empty === 1'b1) && k < max) begin
            tick();
            k++;
        end
        check("drain_done", o_empty, 1);
        repeat (15) tick();
    endtask

    int s0;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_busy  = 1'b0;
        tick();
        tick();
        check("rst_level", o_level, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_ready", o_ready, 1);
        check("rst_write", o_write, 0);
        check("rst_char", o_char, 0);
        check("rst_overflow", o_overflow, 0);
        i_reset = 1'b0;
        lvl_chk = 1;

        // Single byte, uart idle: strobe two edges after the push.
        push_byte(8'h41);
        check("t1_no_early_write", o_write, 0);
        check("t1_level_after_push", o_level, 1);
        tick();
        check("t1_write", o_write, 1);
        check("t1_char", o_char, 8'h41);
        tick();
        check("t1_write_one_cycle", o_write, 0);
        repeat (10) tick();

        // Fill while busy, then overflow.
        i_busy  = 1'b1;
        strobes = 0;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        check("t2_full", o_full, 1);
        check("t2_ready", o_ready, 0);
        check("t2_level", o_level, 16);
        check("t2_no_overflow_yet", o_overflow, 0);
        check("t2_no_strobe_busy", strobes, 0);
        push_byte(8'hEE);
        check("t2_overflow", o_overflow, 1);
        check("t2_level_kept", o_level, 16);
        i_busy   = 1'b0;
        busy_len = 10;
        busy_cnt = 0;
        wr_seen  = 1'b0;
        model_en = 1;
        wait_drain(400);
        check("t2_drain_count", strobes, 16);
        check("t2_overflow_sticky", o_overflow, 1);

        // Three bytes against the busy model.
        strobes = 0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        wait_drain(200);
        check("t3_strobes", strobes, 3);
        check("t3_busy_viol", busy_viol, 0);
        check("t3_double_strobe", dbl_viol, 0);

        // uart_tx never acknowledges: ack timeout frees the sequencer.
        model_en = 0;
        i_busy   = 1'b0;
        busy_cnt = 0;
        wr_seen  = 1'b0;
        repeat (10) tick();
        s0 = strobes;
        push_byte(8'h5A);
        repeat (20) tick();
        check("t4_single_strobe", strobes, s0 + 1);
        push_byte(8'h61);
        push_byte(8'h62);
        repeat (25) tick();
        check("t4_two_strobes", strobes, s0 + 3);
        check("t4_timeout_spacing", last_t - prev_t, 6);

        // Interleaved pushes and drains, pointers wrap.
        busy_len = 3;
        busy_cnt = 0;
        wr_seen  = 1'b0;
        model_en = 1;
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h80 + 8'(i));
            if (i % 4 == 3) repeat (8) tick();
        end
        wait_drain(400);
        check("t5_strobes", strobes, s0 + 20);
        check("t5_busy_viol", busy_viol, 0);
        check("t5_double_strobe", dbl_viol, 0);

        // Reset while waiting for uart_tx to finish, with bytes queued.
        busy_len = 10;
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
        repeat (3) tick();
        check("t6_queued", o_level, 5);
        check("t6_uart_busy", i_busy, 1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t6_level_cleared", o_level, 0);
        check("t6_overflow_cleared", o_overflow, 0);
        check("t6_write_dropped", o_write, 0);
        check("t6_empty", o_empty, 1);
        s0 = strobes;
        push_byte(8'h77);
        check("t6_no_strobe_while_busy", strobes, s0);
        repeat (30) tick();
        check("t6_strobe_after_busy", strobes, s0 + 1);
        check("t6_busy_viol", busy_viol, 0);
        check("t6_final_empty", o_empty, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
